// File: rtl/sri_to_axilite_if.sv
// Bundle of the SRI request/response signals and the AXI4-Lite master signals
// carried by sri_to_axilite.
//
// Modports:
//   master - the bridge side: takes SRI requests and drives the AXI-Lite
//            master channels (AW, W, AR valids/payloads, B/R readies).
//   slave  - the surrounding environment: issues SRI requests and answers on
//            the AXI-Lite channels (AW/W/AR readies, B/R valids/payloads).
//
// Signal names keep their bridge-relative _i/_o suffixes so they line up with
// the bridge's documented pin list.
interface sri_to_axilite_if #(
  parameter int unsigned SRI_ADDR_WIDTH = 20,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH     = 64
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // SRI side
  logic                      sri_en_i;
  logic                      sri_we_i;
  logic [SRI_ADDR_WIDTH-1:0] sri_addr_i;
  logic [DATA_WIDTH-1:0]     sri_wdata_i;
  logic [STRB_WIDTH-1:0]     sri_be_i;
  logic                      sri_busy_o;
  logic                      sri_done_o;
  logic [DATA_WIDTH-1:0]     sri_rdata_o;
  logic                      sri_error_o;

  // AXI4-Lite write address / data / response
  logic [AXI_ADDR_WIDTH-1:0] m_awaddr_o;
  logic                      m_awvalid_o;
  logic                      m_awready_i;
  logic [DATA_WIDTH-1:0]     m_wdata_o;
  logic [STRB_WIDTH-1:0]     m_wstrb_o;
  logic                      m_wvalid_o;
  logic                      m_wready_i;
  logic [1:0]                m_bresp_i;
  logic                      m_bvalid_i;
  logic                      m_bready_o;

  // AXI4-Lite read address / data
  logic [AXI_ADDR_WIDTH-1:0] m_araddr_o;
  logic                      m_arvalid_o;
  logic                      m_arready_i;
  logic [DATA_WIDTH-1:0]     m_rdata_i;
  logic [1:0]                m_rresp_i;
  logic                      m_rvalid_i;
  logic                      m_rready_o;

  modport master (
    input  sri_en_i, sri_we_i, sri_addr_i, sri_wdata_i, sri_be_i,
    output sri_busy_o, sri_done_o, sri_rdata_o, sri_error_o,
    output m_awaddr_o, m_awvalid_o,
    input  m_awready_i,
    output m_wdata_o, m_wstrb_o, m_wvalid_o,
    input  m_wready_i,
    input  m_bresp_i, m_bvalid_i,
    output m_bready_o,
    output m_araddr_o, m_arvalid_o,
    input  m_arready_i,
    input  m_rdata_i, m_rresp_i, m_rvalid_i,
    output m_rready_o
  );

  modport slave (
    output sri_en_i, sri_we_i, sri_addr_i, sri_wdata_i, sri_be_i,
    input  sri_busy_o, sri_done_o, sri_rdata_o, sri_error_o,
    input  m_awaddr_o, m_awvalid_o,
    output m_awready_i,
    input  m_wdata_o, m_wstrb_o, m_wvalid_o,
    output m_wready_i,
    output m_bresp_i, m_bvalid_i,
    input  m_bready_o,
    input  m_araddr_o, m_arvalid_o,
    output m_arready_i,
    output m_rdata_i, m_rresp_i, m_rvalid_i,
    input  m_rready_o
  );
endinterface

// File: rtl/sri_to_axilite.sv
// SRI initiator to AXI4-Lite master bridge.
//
// Each single-beat SRI request accepted while idle becomes exactly one
// AXI4-Lite read or write. Only one transaction is ever in flight; further
// requests are ignored until the bridge returns to idle. Completion is a
// one-cycle sri_done_o pulse with read data and an error flag (response not
// OKAY) that stay held until the next completion. There is no timeout: a
// slave that never responds keeps the bridge busy.
//
// Ports:
//   clk_i   - clock
//   rstn_i  - asynchronous active-low reset; drops every valid/ready at once
//             and discards an in-flight request without a done pulse
//   bus     - sri_to_axilite_if.master: SRI request/response plus the
//             AW, W, B, AR and R AXI4-Lite master channels
//
// Parameters:
//   SRI_ADDR_WIDTH - SRI byte address width
//   AXI_ADDR_WIDTH - AXI address width, must be >= SRI_ADDR_WIDTH
//   DATA_WIDTH     - data width on both sides, must be a multiple of 8
//   ADDR_BASE      - offset added to every (zero-extended) SRI address
//
// The bus interface must be instantiated with the same width parameters.
module sri_to_axilite #(
  parameter int unsigned               SRI_ADDR_WIDTH = 20,
  parameter int unsigned               AXI_ADDR_WIDTH = 32,
  parameter int unsigned               DATA_WIDTH     = 64,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_BASE      = '0
) (
  input logic               clk_i,
  input logic               rstn_i,
  sri_to_axilite_if.master  bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    StIdle,
    StWr,
    StWrResp,
    StRdAddr,
    StRdData,
    StDone
  } state_e;

  state_e                    state_q, state_d;
  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [STRB_WIDTH-1:0]     wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic                      error_q, error_d;
  // Per-channel completion of the AW and W handshakes within one write.
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;

  logic                      awvalid, wvalid, bready, arvalid, rready;
  logic                      aw_hs, w_hs;

  // Valids and readies decode straight from registered state, so reset
  // clears them immediately and they cannot glitch on slave inputs.
  assign awvalid = (state_q == StWr) & ~aw_done_q;
  assign wvalid  = (state_q == StWr) & ~w_done_q;
  assign bready  = (state_q == StWrResp);
  assign arvalid = (state_q == StRdAddr);
  assign rready  = (state_q == StRdData);

  assign aw_hs = awvalid & bus.m_awready_i;
  assign w_hs  = wvalid & bus.m_wready_i;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    rdata_d   = rdata_q;
    error_d   = error_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;

    unique case (state_q)
      StIdle: begin
        if (bus.sri_en_i) begin
          // Sum wraps modulo 2^AXI_ADDR_WIDTH.
          addr_d    = ADDR_BASE + AXI_ADDR_WIDTH'(bus.sri_addr_i);
          wdata_d   = bus.sri_wdata_i;
          wstrb_d   = bus.sri_be_i;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = bus.sri_we_i ? StWr : StRdAddr;
        end
      end

      StWr: begin
        if (aw_hs) aw_done_d = 1'b1;
        if (w_hs)  w_done_d  = 1'b1;
        // AW and W may finish in either order or together.
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          state_d = StWrResp;
        end
      end

      StWrResp: begin
        if (bus.m_bvalid_i) begin
          error_d = (bus.m_bresp_i != 2'b00);
          state_d = StDone;
        end
      end

      StRdAddr: begin
        if (bus.m_arready_i) state_d = StRdData;
      end

      StRdData: begin
        if (bus.m_rvalid_i) begin
          // Data is returned even on an error response.
          rdata_d = bus.m_rdata_i;
          error_d = (bus.m_rresp_i != 2'b00);
          state_d = StDone;
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      rdata_q   <= rdata_d;
      error_q   <= error_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  // SRI outputs
  assign bus.sri_busy_o  = (state_q != StIdle);
  assign bus.sri_done_o  = (state_q == StDone);
  assign bus.sri_rdata_o = rdata_q;
  assign bus.sri_error_o = error_q;

  // AXI outputs; one address register serves both AW and AR since only one
  // of them is ever valid.
  assign bus.m_awaddr_o  = addr_q;
  assign bus.m_awvalid_o = awvalid;
  assign bus.m_wdata_o   = wdata_q;
  assign bus.m_wstrb_o   = wstrb_q;
  assign bus.m_wvalid_o  = wvalid;
  assign bus.m_bready_o  = bready;
  assign bus.m_araddr_o  = addr_q;
  assign bus.m_arvalid_o = arvalid;
  assign bus.m_rready_o  = rready;

endmodule
